// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
//   REG_W / DATA_W : register index and data widths
//   REG_*          : well-known register indices
//   wr_req_t       : one register-file write request {rd, data, jal, we}
//   starve_state_t : starvation-guard states
package regfile_write_arbiter_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_W-1:0] REG_V0   = 5'd2;
  localparam logic [REG_W-1:0] REG_A0   = 5'd4;
  localparam logic [REG_W-1:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic              jal;
    logic              we;
  } wr_req_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } starve_state_t;

  // One-hot mask for a register index; $zero never produces a bit.
  function automatic logic [31:0] reg_onehot(input logic [REG_W-1:0] r);
    logic [31:0] m;
    m = '0;
    if (r != REG_ZERO) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_write_fifo.sv
// Small synchronous FIFO holding pending MDU register writes.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_push/i_data  : enqueue (ignored when full)
//   i_pop          : dequeue head (ignored when empty)
//   o_head         : current head entry
//   o_count        : occupancy 0..DEPTH
//   o_full/o_empty : occupancy flags
module write_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  wr_req_t                  i_data,
  input  logic                     i_pop,
  output wr_req_t                  o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wr_req_t           r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the in-order WB stage
// (priority) and the MDU (via a skid FIFO with valid/ready). A starvation
// guard forces one MDU drain after STARVE_LIMIT consecutive WB wins, and a
// pending-destination scoreboard feeds the decode hazard check.
//   wb_*               : WB write request
//   mdu_valid/ready/rd/data : MDU result handshake
//   mdu_issue/_rd      : MDU op issue, marks destination pending
//   q_rs/q_rt/q_rd     : decode hazard queries -> hazard
//   stall_wb           : WB must hold its write this cycle
//   rf_*               : registered register-file write port
//   fifo_count         : MDU FIFO occupancy
//   err_sticky         : double issue or unexpected MDU result seen
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_we,
  input  logic                    wb_jal,
  input  logic [REG_W-1:0]        wb_rd,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    mdu_valid,
  output logic                    mdu_ready,
  input  logic [REG_W-1:0]        mdu_rd,
  input  logic [DATA_W-1:0]       mdu_data,
  input  logic                    mdu_issue,
  input  logic [REG_W-1:0]        mdu_issue_rd,
  input  logic [REG_W-1:0]        q_rs,
  input  logic [REG_W-1:0]        q_rt,
  input  logic [REG_W-1:0]        q_rd,
  output logic                    hazard,
  output logic                    stall_wb,
  output logic [REG_W-1:0]        rf_rd,
  output logic [DATA_W-1:0]       rf_write_data,
  output logic                    rf_sig_jal,
  output logic                    rf_sig_reg_write,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    err_sticky
);

  localparam int unsigned          CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  logic           r_ready_en;
  starve_state_t  r_state;
  starve_state_t  w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]    r_pending;
  logic [31:0]    w_pending_nxt;
  logic [31:0]    w_set_mask;
  logic [31:0]    w_clr_mask;
  logic           r_err;
  logic           w_err_evt;
  wr_req_t        r_wr;
  wr_req_t        w_push_req;
  wr_req_t        w_head;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_stall;
  logic           w_wb_grant;

  // ready is held low until the first edge after reset release
  assign mdu_ready  = r_ready_en & ~w_full;
  assign w_push     = mdu_valid & mdu_ready;
  assign w_stall    = (r_state == ST_FORCE);
  assign w_wb_grant = wb_we & ~w_stall;
  assign w_pop      = ~w_wb_grant & ~w_empty;
  assign w_push_req = '{rd: mdu_rd, data: mdu_data, jal: 1'b0, we: 1'b1};

  write_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Scoreboard: set after clear so a same-cycle set of the same bit wins.
  always_comb begin
    w_set_mask    = mdu_issue ? reg_onehot(mdu_issue_rd) : '0;
    w_clr_mask    = w_pop ? reg_onehot(w_head.rd) : '0;
    w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
  end

  assign w_err_evt = (mdu_issue && r_pending[mdu_issue_rd])
                   || (w_push && (mdu_rd != REG_ZERO) && !r_pending[mdu_rd]);

  assign hazard = r_pending[q_rs] | r_pending[q_rt] | r_pending[q_rd];

  // Starvation guard: count WB wins while MDU data waits; any pop or an
  // empty FIFO restarts the count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_starve_cnt;
    case (r_state)
      ST_NORMAL: begin
        if (w_pop || w_empty) begin
          w_cnt_nxt = '0;
        end else if (w_wb_grant) begin
          if (r_starve_cnt == CNT_LAST) begin
            w_state_nxt = ST_FORCE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_starve_cnt + CNT_W'(1);
          end
        end
      end
      ST_FORCE: begin
        w_state_nxt = ST_NORMAL;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_NORMAL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en   <= 1'b0;
      r_state      <= ST_NORMAL;
      r_starve_cnt <= '0;
      r_pending    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_ready_en   <= 1'b1;
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_cnt_nxt;
      r_pending    <= w_pending_nxt;
      if (w_err_evt) r_err <= 1'b1;
    end
  end

  // Write port: rd/data hold when idle, only the strobes drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
    end else if (w_wb_grant) begin
      r_wr <= '{rd: wb_rd, data: wb_data, jal: wb_jal, we: 1'b1};
    end else if (w_pop) begin
      r_wr <= '{rd: w_head.rd, data: w_head.data, jal: w_head.jal,
                we: w_head.we & (w_head.rd != REG_ZERO)};
    end else begin
      r_wr.jal <= 1'b0;
      r_wr.we  <= 1'b0;
    end
  end

  assign stall_wb         = w_stall;
  assign rf_rd            = r_wr.rd;
  assign rf_write_data    = r_wr.data;
  assign rf_sig_jal       = r_wr.jal;
  assign rf_sig_reg_write = r_wr.we;
  assign err_sticky       = r_err;

endmodule
